// File: rtl/pcihellocore_fan_tach.sv
// Avalon-MM fan tachometer: counts tach pulses per gate window and flags fan stall.
// Optional input debounce filter enabled by defining PCIHELLOCORE_FAN_TACH_DEBOUNCE_EN.
module pcihellocore_fan_tach #(
   parameter int GATE_CYCLES     = 50000000,
   parameter int CNT_W           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        tach_in,
   output logic        irq
);

   localparam int                GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{CNT_W{1'b0}}, inc};
      return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level;
   logic                   prev_q;
   logic                   edge_det;
   logic                   unused_wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], tach_in};
   end

`ifdef PCIHELLOCORE_FAN_TACH_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;

   logic            filt_q, filt_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   // The filtered level follows the synchroniser only after a full run of stable disagreement.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (sync_q[SYNC_STAGES-1] != filt_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) filt_d = sync_q[SYNC_STAGES-1];
         else                                        db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q   <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign level = filt_q;
`else
   logic unused_dbc;
   assign unused_dbc = (DEBOUNCE_CYCLES > 0);
   assign level      = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev_q <= 1'b0;
      else          prev_q <= level;
   end

   assign edge_det     = level & ~prev_q;
   assign unused_wdata = ^writedata;

   logic              enable_q, enable_d;
   logic              irq_en_q, irq_en_d;
   logic [CNT_W-1:0]  thr_q, thr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              valid_q, valid_d;
   logic              stall_q, stall_d;
   logic              ovf_q, ovf_d;
   logic              irq_q, irq_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  pulse_q, pulse_d;

   logic              wr_stb;
   logic              terminal;
   logic              cnt_edge;
   logic [CNT_W-1:0]  pulse_sum;
   logic              ovf_set;
   logic              stall_set;
   logic [1:0]        w1c;

   always_comb begin
      wr_stb    = chipselect & ~write_n;
      cnt_edge  = enable_q & edge_det;
      terminal  = enable_q && (gate_q == GATE_LAST);
      pulse_sum = sat_inc(pulse_q, cnt_edge);
      ovf_set   = cnt_edge && (pulse_q == CNT_MAX);
      stall_set = terminal && (pulse_sum < thr_q);
      w1c       = (wr_stb && address == 2'd3) ? writedata[1:0] : 2'b00;

      gate_d   = gate_q;
      pulse_d  = pulse_q;
      count_d  = count_q;
      valid_d  = valid_q;
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      thr_d    = thr_q;

      if (!enable_q) begin
         gate_d  = '0;
         pulse_d = '0;
      end else if (terminal) begin
         // An edge landing on the terminal cycle still belongs to the closing window.
         gate_d  = '0;
         pulse_d = '0;
         count_d = pulse_sum;
         valid_d = 1'b1;
      end else begin
         gate_d  = gate_q + GATE_W'(1);
         pulse_d = pulse_sum;
      end

      if (wr_stb && address == 2'd1) begin
         enable_d = writedata[0];
         irq_en_d = writedata[1];
      end
      if (wr_stb && address == 2'd2) thr_d = writedata[CNT_W-1:0];

      // Hardware set beats a simultaneous write-1-to-clear.
      stall_d = (stall_q & ~w1c[0]) | stall_set;
      ovf_d   = (ovf_q & ~w1c[1]) | ovf_set;
      irq_d   = irq_en_q & stall_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q <= 1'b1;
         irq_en_q <= 1'b0;
         thr_q    <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
         gate_q   <= '0;
         pulse_q  <= '0;
      end else begin
         enable_q <= enable_d;
         irq_en_q <= irq_en_d;
         thr_q    <= thr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
         gate_q   <= gate_d;
         pulse_q  <= pulse_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: begin
            readdata[CNT_W-1:0] = count_q;
            readdata[31]        = valid_q;
         end
         2'd1:    readdata[1:0]       = {irq_en_q, enable_q};
         2'd2:    readdata[CNT_W-1:0] = thr_q;
         default: readdata[1:0]       = {ovf_q, stall_q};
      endcase
   end

   assign irq = irq_q;

endmodule

// File: doc/pcihellocore_fan_tach.md
Name: pcihellocore_fan_tach

Overview:
Avalon-MM slave tachometer reader for the board fan. It is the read-back counterpart of the fan control output register. It synchronises the fan tach pulse input, counts rising edges over a fixed gate window, and latches the count for the host to read over PCIe. It raises a level interrupt when the measured count falls below a host-programmed stall threshold.

Parameters:
GATE_CYCLES, 50000000, clk cycles per measurement window (1 s at 50 MHz); minimum 2.
CNT_W, 16, pulse counter width, 1..31.
SYNC_STAGES, 2, tach_in synchroniser depth, minimum 2.
DEBOUNCE_CYCLES, 4, filter length; used only with PCIHELLOCORE_FAN_TACH_DEBOUNCE_EN.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address (zero wait states)
tach_in  in  1  asynchronous fan tach pulse
irq  out  1  level interrupt, registered

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All flops are cleared on reset except CONTROL.enable, which resets to 1. Reset values: irq=0; readdata at addr0=0, addr1=0x1, addr2=0, addr3=0.
- Register map (write strobe = chipselect & ~write_n):
  - addr0 COUNT (RO): [CNT_W-1:0] = last latched count; [31] = valid; other bits 0. Writes are ignored.
  - addr1 CONTROL (RW): [0] enable; [1] irq_en; other bits read 0.
  - addr2 THRESHOLD (RW): [CNT_W-1:0] stall threshold; other bits read 0.
  - addr3 STATUS: [0] stall, [1] overflow. Both bits are sticky and write-1-to-clear.
- Input path: SYNC_STAGES flops reset to 0, then a prev flop. edge = sync & ~prev. A tach_in rising edge produces edge exactly SYNC_STAGES+1 cycles later (without debounce).
- Gate counter: runs 0..GATE_CYCLES-1 while enable=1. At the terminal cycle (gate == GATE_CYCLES-1):
  - COUNT <= pulse_cnt + edge, saturated.
  - valid <= 1.
  - pulse_cnt <= 0.
  - gate <= 0.
  - stall set if the latched value < THRESHOLD.
  - An edge on the terminal cycle belongs to the closing window.
- Pulse counter:
  - Increments on edge and saturates at 2^CNT_W-1.
  - An edge arriving while saturated sets overflow.
  - Overflow is also set if the terminal-cycle sum saturates.
- enable=0:
  - gate and pulse_cnt are held at 0; edges are ignored.
  - COUNT, valid and STATUS are retained.
  - Writing enable 0->1 starts a fresh window; gate begins counting on the cycle after the write.
  - Writing enable=1 while already 1 does not restart the window.
- A THRESHOLD write takes effect at the next window end. It does not restart the window and does not re-evaluate the current stall bit.
- W1C to STATUS in the same cycle as a hardware set: the set wins and the bit stays 1.
- irq is registered: irq <= irq_en & stall. It asserts 1 cycle after stall sets or irq_en is written to 1. It deasserts 1 cycle after the clear.
- THRESHOLD=0: stall can never set.
- Reads have no side effects.
- Reset asserted mid-window: everything returns to reset values immediately; the first window after release starts from gate=0.

Optional Feature:
PCIHELLOCORE_FAN_TACH_DEBOUNCE_EN:
- Defined: a filter sits between the synchroniser and the prev flop. The filtered level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; the stability counter restarts on any bounce. Edge latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles. Pulses shorter than DEBOUNCE_CYCLES cycles are not counted.
- Undefined: no filter; DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset release: read addr0..3 -> 0x0, 0x1, 0x0, 0x0; irq=0.
- GATE_CYCLES=100, 10-cycle-period tach (5 high/5 low) from cycle 0 -> after first window COUNT = 0x8000000A (±1 allowed only for first-window phase); second window exactly 0x8000000A.
- THRESHOLD=20, CONTROL=0x3, tach as above -> at window end STATUS=0x1; irq=1 one cycle later. Write STATUS=0x1 -> irq=0 next cycle; stall re-sets at the following window end.
- CNT_W=4, tach period 4 cycles, GATE_CYCLES=100 -> COUNT[3:0]=0xF, STATUS[1]=1.
- Mid-window write CONTROL=0x0, then 0x1 after 50 cycles -> no window end for 100 cycles after re-enable; previous COUNT is retained meanwhile.
- With DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitches produce COUNT[CNT_W-1:0]=0; 8-cycle pulses are counted normally. Without the macro, the same 2-cycle glitches are counted.
